// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: operand select encoding and the
// per-stage tracking slot.
package fwd_pkg;

    // Slots store rd at this width; narrower register indices are zero-extended.
    localparam int unsigned RegAddrMaxW = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_WB    = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                   valid;
        logic [RegAddrMaxW-1:0] rd;
        logic                   regwrite;
        logic                   memread;
    } fwd_slot_t;

endpackage

// File: rtl/fwd_operand_cmp.sv
// Per-operand dependency check against the EX and MEM tracking slots; yields the
// next forwarding select and whether the operand depends on a load still in EX.
module fwd_operand_cmp
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  fwd_slot_t             ex_slot_i,
    input  fwd_slot_t             mem_slot_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  uses_i,
    output fwd_sel_e              sel_next_o,
    output logic                  load_hit_o
);

    logic [RegAddrMaxW-1:0] rs_ext;
    logic                   ex_hit;
    logic                   mem_hit;
    logic                   unused_mem_memread;

    assign rs_ext = RegAddrMaxW'(rs_i);

    // x0 is hard-wired to zero, so writes to it never create a dependency.
    assign ex_hit  = ex_slot_i.valid & ex_slot_i.regwrite & (ex_slot_i.rd != '0)
                   & (ex_slot_i.rd == rs_ext) & uses_i;
    assign mem_hit = mem_slot_i.valid & mem_slot_i.regwrite & (mem_slot_i.rd != '0)
                   & (mem_slot_i.rd == rs_ext) & uses_i;

    // A load in MEM already has its data on the writeback path.
    assign unused_mem_memread = mem_slot_i.memread;

    always_comb begin
        sel_next_o = FWD_RF;
        if (ex_hit) begin
            sel_next_o = FWD_EXMEM;
        end else if (mem_hit) begin
            sel_next_o = FWD_WB;
        end
    end

    assign load_hit_o = ex_hit & ex_slot_i.memread;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use stall control for a 5-stage pipeline.
// Define FWD_HAZARD_PERF_EN to add the stall_cycles performance counter output.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    input  logic                  pipe_hold,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    fwd_slot_t ex_q, ex_d;
    fwd_slot_t mem_q, mem_d;
    fwd_sel_e  sel_a_q, sel_a_d;
    fwd_sel_e  sel_b_q, sel_b_d;
    fwd_sel_e  sel_a_next, sel_b_next;
    logic      load_hit_a, load_hit_b;
    logic      issue;

    fwd_operand_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp_a (
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .rs_i       (id_rs1),
        .uses_i     (id_uses_rs1),
        .sel_next_o (sel_a_next),
        .load_hit_o (load_hit_a)
    );

    fwd_operand_cmp #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp_b (
        .ex_slot_i  (ex_q),
        .mem_slot_i (mem_q),
        .rs_i       (id_rs2),
        .uses_i     (id_uses_rs2),
        .sel_next_o (sel_b_next),
        .load_hit_o (load_hit_b)
    );

    // Slots are cleared asynchronously, so stall drops as soon as rst rises.
    assign stall = id_valid & ~flush & (load_hit_a | load_hit_b);
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        if (!pipe_hold) begin
            mem_d   = ex_q;
            ex_d    = '0;
            sel_a_d = FWD_RF;
            sel_b_d = FWD_RF;
            if (issue) begin
                ex_d.valid    = 1'b1;
                ex_d.rd       = RegAddrMaxW'(id_rd);
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = id_memread;
                sel_a_d       = sel_a_next;
                sel_b_d       = sel_b_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign fwd_a_sel = sel_a_q;
    assign fwd_b_sel = sel_b_q;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !pipe_hold) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit: forwarding, load-use stall,
// x0 handling, flush, pipe_hold and reset behaviour.
module tb_fwd_hazard_unit;

    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_uses_rs1, id_uses_rs2;
    logic          id_regwrite, id_memread;
    logic          flush, pipe_hold;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_unit #(
        .REG_ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .pipe_hold   (pipe_hold),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic u1, input logic u2, input logic [AW-1:0] rd,
                            input logic rw, input logic mr);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        pipe_hold = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_sel_a", fwd_a_sel, 2'b00);
        check_eq("rst_sel_b", fwd_b_sel, 2'b00);
`ifdef FWD_HAZARD_PERF_EN
        check_eq("rst_perf", stall_cycles, 0);
`endif
        tick();
        rst = 1'b0;

        // add x5 ; add x6,x5,x1
        drive_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(1, 5, 1, 1, 1, 6, 1, 0);
        #1;
        check_eq("exfwd_stall", stall, 0);
        tick();
        check_eq("exfwd_sel_a", fwd_a_sel, 2'b10);
        check_eq("exfwd_sel_b", fwd_b_sel, 2'b00);
        drain();

        // add x5 ; nop ; sub x7,x2,x5
        drive_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive_id(1, 2, 5, 1, 1, 7, 1, 0);
        tick();
        check_eq("memfwd_sel_a", fwd_a_sel, 2'b00);
        check_eq("memfwd_sel_b", fwd_b_sel, 2'b01);
        drain();

        // lw x8 ; add x9,x8,x8
        drive_id(1, 0, 0, 0, 0, 8, 1, 1);
        tick();
        drive_id(1, 8, 8, 1, 1, 9, 1, 0);
        #1;
        check_eq("lu_stall_on", stall, 1);
        tick();
        check_eq("lu_stall_off", stall, 0);
        check_eq("lu_bubble_a", fwd_a_sel, 2'b00);
        check_eq("lu_bubble_b", fwd_b_sel, 2'b00);
        tick();
        check_eq("lu_sel_a", fwd_a_sel, 2'b01);
        check_eq("lu_sel_b", fwd_b_sel, 2'b01);
`ifdef FWD_HAZARD_PERF_EN
        check_eq("lu_perf", stall_cycles, 1);
`endif
        drain();

        // x0 destination never forwards or stalls
        drive_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive_id(1, 0, 0, 1, 1, 4, 1, 0);
        #1;
        check_eq("x0_stall", stall, 0);
        tick();
        check_eq("x0_sel_a", fwd_a_sel, 2'b00);
        check_eq("x0_sel_b", fwd_b_sel, 2'b00);
        drain();
        drive_id(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        drive_id(1, 0, 0, 1, 1, 4, 1, 0);
        #1;
        check_eq("x0_load_stall", stall, 0);
        drain();

        // x5 in both EX and MEM: EX wins
        drive_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        tick();
        drive_id(1, 5, 5, 1, 1, 6, 1, 0);
        tick();
        check_eq("prio_sel_a", fwd_a_sel, 2'b10);
        check_eq("prio_sel_b", fwd_b_sel, 2'b10);
        drain();

        // load-use with flush in the same cycle
        drive_id(1, 0, 0, 0, 0, 8, 1, 1);
        tick();
        drive_id(1, 8, 8, 1, 1, 9, 1, 0);
        flush = 1'b1;
        #1;
        check_eq("flush_stall", stall, 0);
        tick();
        flush = 1'b0;
        check_eq("flush_sel_a", fwd_a_sel, 2'b00);
        check_eq("flush_sel_b", fwd_b_sel, 2'b00);
        drive_id(1, 9, 8, 1, 1, 10, 1, 0);
        #1;
        check_eq("flush_ex_bubble", stall, 0);
        tick();
        check_eq("flush_after_a", fwd_a_sel, 2'b00);
        check_eq("flush_after_b", fwd_b_sel, 2'b01);
        drain();

        // pipe_hold during a load-use stall, then reset
        drive_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        drive_id(1, 3, 0, 1, 0, 8, 1, 1);
        tick();
        drive_id(1, 8, 8, 1, 1, 9, 1, 0);
        pipe_hold = 1'b1;
        #1;
        check_eq("hold_stall_0", stall, 1);
        check_eq("hold_sel_a_0", fwd_a_sel, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_stall", stall, 1);
            check_eq("hold_sel_a", fwd_a_sel, 2'b10);
            check_eq("hold_sel_b", fwd_b_sel, 2'b00);
`ifdef FWD_HAZARD_PERF_EN
            check_eq("hold_perf", stall_cycles, 1);
`endif
        end
        rst = 1'b1;
        #1;
        check_eq("mid_rst_stall", stall, 0);
        check_eq("mid_rst_sel_a", fwd_a_sel, 2'b00);
        check_eq("mid_rst_sel_b", fwd_b_sel, 2'b00);
`ifdef FWD_HAZARD_PERF_EN
        check_eq("mid_rst_perf", stall_cycles, 0);
`endif
        rst = 1'b0;
        pipe_hold = 1'b0;
        #1;
        check_eq("post_rst_stall", stall, 0);
        tick();
        check_eq("post_rst_sel_a", fwd_a_sel, 2'b00);
        check_eq("post_rst_sel_b", fwd_b_sel, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  valid instruction in ID.
REQ-005 SHALL have ports id_rs1, id_rs2  input  REG_ADDR_W  ID source registers.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1  source actually read.
REQ-007 SHALL have ports id_rd  input  REG_ADDR_W, id_regwrite  input  1, id_memread  input  1  ID destination info.
REQ-008 SHALL have port flush  input  1  squash the ID instruction (taken branch/jump).
REQ-009 SHALL have port pipe_hold  input  1  external freeze (memory busy).
REQ-010 SHALL have ports fwd_a_sel, fwd_b_sel  output  2  registered selects for the EX operand 3:1 muxes.
REQ-011 SHALL have port stall  output  1  hold PC and IF/ID; insert bubble into ID/EX.

Function
REQ-012 SHALL keep two tracking slots, EX and MEM, each holding {valid, rd, regwrite, memread}.
REQ-013 Select encoding SHALL be 00 regfile, 01 MEM/WB writeback value, 10 EX/MEM ALU result; 11 never driven.
REQ-014 A slot SHALL match a source only if: valid, regwrite, rd != 0, rd == rs, and the matching id_uses_rsN is 1.
REQ-015 Next sel per operand SHALL be 10 on an EX-slot match, else 01 on a MEM-slot match, else 00; EX slot has priority.
REQ-016 stall SHALL be combinational: id_valid & !flush & (EX-slot match with EX.memread=1) on either operand.
REQ-017 On each edge with pipe_hold=0: MEM <= EX; EX <= ID info if id_valid & !stall & !flush, else invalid (bubble).
REQ-018 fwd_a_sel/fwd_b_sel SHALL register the REQ-015 result on each edge with pipe_hold=0; they SHALL load 00 when stall or flush is 1 or id_valid is 0.
REQ-019 With pipe_hold=1, slots and sel registers SHALL hold; stall SHALL still be computed from the held slots.
REQ-020 flush SHALL take effect only when pipe_hold=0; the controller holds flush until then.
REQ-021 Load-use SHALL cost exactly one stall cycle; the following cycle the load sits in MEM slot and the dependent gets sel 01.
REQ-022 Writeback-stage hazards SHALL NOT be forwarded; the regfile is write-first.
REQ-023 Forwarding latency: sel SHALL be valid in the same cycle the instruction is in EX (one edge after ID).

Reset
REQ-024 rst SHALL asynchronously clear both slots to invalid and fwd_a_sel/fwd_b_sel to 00; stall SHALL read 0 while rst is asserted.
REQ-025 Reset asserted mid-stall SHALL drop stall immediately; the first post-reset instruction SHALL see sel 00.

Configuration
REQ-026 With FWD_HAZARD_PERF_EN defined, a 32-bit output stall_cycles SHALL count cycles with stall=1 & pipe_hold=0, wrap at 2^32, and reset to 0.
REQ-027 Without FWD_HAZARD_PERF_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package fwd_pkg SHALL hold the select enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10) and the slot struct typedef.
REQ-029 A sub-module fwd_operand_cmp SHALL be instantiated per operand, taking both slots and rs/uses and returning the next sel and a load-hit flag.

Verification
REQ-030 add x5 then add x6,x5,x1 back-to-back -> fwd_a_sel=10 in the second instruction's EX cycle; stall=0.
REQ-031 add x5; nop; sub x7,x2,x5 -> fwd_b_sel=01 in sub's EX cycle.
REQ-032 lw x8 then add x9,x8,x8 -> stall=1 for exactly one cycle, bubble in EX, then both sels 01.
REQ-033 Write to x0 followed by a read of x0 -> sels 00, stall 0; x5 in both EX and MEM slots -> sel 10.
REQ-034 Load-use with flush=1 in the same cycle -> stall=0, EX slot bubble, sels 00 next cycle.
REQ-035 pipe_hold=1 for 3 cycles during a load-use stall, then rst pulse -> slots and sels frozen while held; rst clears sels to 00 and stall to 0 at once; stall_cycles (if FWD_HAZARD_PERF_EN) unchanged during hold, 0 after reset.
